// File: rtl/trip_ctrl_pkg.sv
// Shared trip-state encodings and distance limit for the taxi meter front-end.
package trip_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } trip_state_t;

  localparam logic [19:0] DIST_MAX = 20'hFFFFF;

endpackage

// File: rtl/trip_ctrl_key_filter.sv
// Push-button debouncer: 2-flop synchroniser plus stable-low timer, one press strobe per press.
module key_filter
  import trip_ctrl_pkg::*;
#(
  parameter logic [19:0] CNT_20MS = 20'd999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag
);

  logic        key_p0;
  logic        key_p1;
  logic        key_prev;
  logic [19:0] cnt;

  // Counter saturates at CNT_20MS so a held key strobes once; any high sample re-arms it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_p0   <= 1'b1;
      key_p1   <= 1'b1;
      key_prev <= 1'b1;
      cnt      <= '0;
      key_flag <= 1'b0;
    end else begin
      key_p0   <= key_in;
      key_p1   <= key_p0;
      key_prev <= key_p1;
      key_flag <= 1'b0;
      if ((key_p1 != key_prev) || key_p1) begin
        cnt <= '0;
      end else if (cnt != CNT_20MS) begin
        cnt <= cnt + 20'd1;
        if (cnt == CNT_20MS - 20'd1)
          key_flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/trip_ctrl.sv
// Taxi meter front-end: debounced keys, trip FSM, encoder prescaler and the
// registered encoder_pulses strobe that clocks the downstream fare counter.
module trip_ctrl
  import trip_ctrl_pkg::*;
#(
  parameter logic [19:0] CNT_20MS        = 20'd999_999,
  parameter logic [15:0] PULSES_PER_UNIT = 16'd1000,
  parameter logic [3:0]  PULSE_W         = 4'd4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        key_launch,
  input  logic        key_step,
  input  logic        encoder_raw,
  output logic        flag_key_launch,
  output logic        flag_key_step,
  output logic [19:0] distance,
  output logic        encoder_pulses
);

  logic        launch_flag;
  logic        step_flag;
  logic        enc_p0;
  logic        enc_p1;
  logic        enc_p2;
  logic        enc_rise;
  logic        trip_end;
  logic        inc_p1;
  logic        pulse_pend;
  logic        pulse_start;
  logic [3:0]  pw_cnt;
  logic [15:0] presc;
  trip_state_t state;

  key_filter #(.CNT_20MS(CNT_20MS)) u_key_launch (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in   (key_launch),
    .key_flag (launch_flag)
  );

  key_filter #(.CNT_20MS(CNT_20MS)) u_key_step (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in   (key_step),
    .key_flag (step_flag)
  );

  // Encoder synchroniser: p0/p1 resolve metastability, p2 holds the previous level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      enc_p0 <= 1'b0;
      enc_p1 <= 1'b0;
      enc_p2 <= 1'b0;
    end else begin
      enc_p0 <= encoder_raw;
      enc_p1 <= enc_p0;
      enc_p2 <= enc_p1;
    end
  end

  assign enc_rise = enc_p1 & ~enc_p2;
  assign trip_end = launch_flag & (state != ST_IDLE);

  // Trip FSM and distance accumulation; inc_p1 marks the cycle after a distance increment.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= ST_IDLE;
      flag_key_launch <= 1'b0;
      flag_key_step   <= 1'b0;
      distance        <= '0;
      presc           <= '0;
      inc_p1          <= 1'b0;
    end else begin
      inc_p1 <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (launch_flag) begin
            state           <= ST_RUN;
            flag_key_launch <= 1'b1;
            flag_key_step   <= 1'b0;
            distance        <= '0;
            presc           <= '0;
          end
        end
        ST_RUN: begin
          if (launch_flag) begin
            state           <= ST_IDLE;
            flag_key_launch <= 1'b0;
            flag_key_step   <= 1'b0;
          end else if (step_flag) begin
            state           <= ST_WAIT;
            flag_key_launch <= 1'b1;
            flag_key_step   <= 1'b1;
          end
          if (enc_rise) begin
            if (presc == PULSES_PER_UNIT - 16'd1) begin
              presc <= '0;
              if (distance != DIST_MAX) begin
                distance <= distance + 20'd1;
                inc_p1   <= 1'b1;
              end
            end else begin
              presc <= presc + 16'd1;
            end
          end
        end
        ST_WAIT: begin
          if (launch_flag) begin
            state           <= ST_IDLE;
            flag_key_launch <= 1'b0;
            flag_key_step   <= 1'b0;
          end else if (step_flag) begin
            state           <= ST_RUN;
            flag_key_launch <= 1'b1;
            flag_key_step   <= 1'b0;
          end
        end
        default: begin
          state           <= ST_IDLE;
          flag_key_launch <= 1'b0;
          flag_key_step   <= 1'b0;
        end
      endcase
    end
  end

  // A new pulse needs at least one low cycle after the previous one. Pending is
  // single-deep: a second increment while one is already pending is dropped, which
  // cannot happen while PULSES_PER_UNIT > PULSE_W + 2.
  assign pulse_start = inc_p1 | (pulse_pend & ~trip_end);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      encoder_pulses <= 1'b0;
      pw_cnt         <= '0;
      pulse_pend     <= 1'b0;
    end else if (encoder_pulses) begin
      if (pw_cnt == PULSE_W - 4'd1) begin
        encoder_pulses <= 1'b0;
        pw_cnt         <= '0;
      end else begin
        pw_cnt <= pw_cnt + 4'd1;
      end
      if (trip_end)
        pulse_pend <= 1'b0;
      else if (inc_p1)
        pulse_pend <= 1'b1;
    end else begin
      pw_cnt <= '0;
      if (pulse_start)
        encoder_pulses <= 1'b1;
      pulse_pend <= pulse_pend & inc_p1 & ~trip_end;
    end
  end

endmodule

// File: tb/tb_trip_ctrl.sv
// Directed bench for trip_ctrl with CNT_20MS=3, PULSES_PER_UNIT=3, PULSE_W=2.
module tb_trip_ctrl;
  import trip_ctrl_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        key_launch;
  logic        key_step;
  logic        encoder_raw;
  logic        flag_key_launch;
  logic        flag_key_step;
  logic [19:0] distance;
  logic        encoder_pulses;

  int n_pass  = 0;
  int n_total = 0;

  trip_ctrl #(
    .CNT_20MS       (20'd3),
    .PULSES_PER_UNIT(16'd3),
    .PULSE_W        (4'd2)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .key_launch     (key_launch),
    .key_step       (key_step),
    .encoder_raw    (encoder_raw),
    .flag_key_launch(flag_key_launch),
    .flag_key_step  (flag_key_step),
    .distance       (distance),
    .encoder_pulses (encoder_pulses)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
  endtask

  // Full press: hold low 10 cycles, then release and let the filter settle.
  task automatic press(input bit do_launch, input bit do_step);
    if (do_launch) key_launch = 1'b0;
    if (do_step)   key_step   = 1'b0;
    tick(10);
    key_launch = 1'b1;
    key_step   = 1'b1;
    tick(6);
  endtask

  // One encoder edge over 10 cycles; samples distance after the 2nd and 3rd
  // clock edges and encoder_pulses after the 3rd..6th.
  task automatic enc_edge(output logic [19:0] d_e1, output logic [19:0] d_e2,
                          output logic [3:0] pls);
    encoder_raw = 1'b1;
    tick(2);
    d_e1 = distance;
    tick(1);
    d_e2   = distance;
    pls[0] = encoder_pulses;
    tick(1); pls[1] = encoder_pulses;
    tick(1); pls[2] = encoder_pulses;
    tick(1); pls[3] = encoder_pulses;
    encoder_raw = 1'b0;
    tick(4);
  endtask

  task automatic bounce_then_launch(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      key_launch = i[0];
      for (int j = 0; j < 2; j++) begin
        tick(1);
        seen = seen | flag_key_launch;
      end
    end
    n_total++; if (seen !== 1'b0) $display("FAIL %s_bounce: got flag %b want 0", tag, seen); else n_pass++;
    key_launch = 1'b0;
    tick(6);
    n_total++; if (flag_key_launch !== 1'b0) $display("FAIL %s_early: got %b want 0", tag, flag_key_launch); else n_pass++;
    tick(1);
    n_total++; if (flag_key_launch !== 1'b1) $display("FAIL %s_launch: got %b want 1", tag, flag_key_launch); else n_pass++;
    n_total++; if (flag_key_step !== 1'b0) $display("FAIL %s_step: got %b want 0", tag, flag_key_step); else n_pass++;
    n_total++; if (distance !== 20'd0) $display("FAIL %s_dist: got %h want 0", tag, distance); else n_pass++;
    tick(3);
    key_launch = 1'b1;
    tick(6);
    n_total++; if (flag_key_launch !== 1'b1) $display("FAIL %s_single: got %b want 1", tag, flag_key_launch); else n_pass++;
  endtask

  task automatic test_reset;
    sys_rst_n   = 1'b0;
    key_launch  = 1'b1;
    key_step    = 1'b1;
    encoder_raw = 1'b0;
    tick(2);
    n_total++; if (flag_key_launch !== 1'b0) $display("FAIL rst_launch: got %b want 0", flag_key_launch); else n_pass++;
    n_total++; if (flag_key_step !== 1'b0) $display("FAIL rst_step: got %b want 0", flag_key_step); else n_pass++;
    n_total++; if (distance !== 20'd0) $display("FAIL rst_dist: got %h want 0", distance); else n_pass++;
    n_total++; if (encoder_pulses !== 1'b0) $display("FAIL rst_pulse: got %b want 0", encoder_pulses); else n_pass++;
    sys_rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_launch_debounce;
    bounce_then_launch("deb");
  endtask

  task automatic test_count;
    logic [19:0] d1, d2, exp_prev, exp_d;
    logic [3:0]  pls, exp_pls;
    exp_d = 20'd0;
    for (int k = 1; k <= 7; k++) begin
      exp_prev = exp_d;
      if (k % 3 == 0) exp_d = exp_d + 20'd1;
      exp_pls = (k % 3 == 0) ? 4'b0110 : 4'b0000;
      enc_edge(d1, d2, pls);
      n_total++; if (d1 !== exp_prev) $display("FAIL cnt_before_e%0d: got %h want %h", k, d1, exp_prev); else n_pass++;
      n_total++; if (d2 !== exp_d) $display("FAIL cnt_after_e%0d: got %h want %h", k, d2, exp_d); else n_pass++;
      n_total++; if (pls !== exp_pls) $display("FAIL cnt_pulse_e%0d: got %b want %b", k, pls, exp_pls); else n_pass++;
    end
    n_total++; if (dut.presc !== 16'd1) $display("FAIL cnt_presc: got %0d want 1", dut.presc); else n_pass++;
  endtask

  task automatic test_wait;
    logic [19:0] d1, d2;
    logic [3:0]  pls;
    enc_edge(d1, d2, pls);
    n_total++; if (d2 !== 20'd2 || pls !== 4'b0000) $display("FAIL wait_pre: got %h/%b want 2/0000", d2, pls); else n_pass++;
    press(1'b0, 1'b1);
    n_total++; if ({flag_key_launch, flag_key_step} !== 2'b11) $display("FAIL wait_enter: got %b want 11", {flag_key_launch, flag_key_step}); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      enc_edge(d1, d2, pls);
      n_total++; if (d2 !== 20'd2 || pls !== 4'b0000) $display("FAIL wait_edge%0d: got %h/%b want 2/0000", k, d2, pls); else n_pass++;
    end
    press(1'b0, 1'b1);
    n_total++; if ({flag_key_launch, flag_key_step} !== 2'b10) $display("FAIL wait_resume: got %b want 10", {flag_key_launch, flag_key_step}); else n_pass++;
    enc_edge(d1, d2, pls);
    n_total++; if (d1 !== 20'd2) $display("FAIL wait_ret_before: got %h want 2", d1); else n_pass++;
    n_total++; if (d2 !== 20'd3) $display("FAIL wait_ret_after: got %h want 3", d2); else n_pass++;
    n_total++; if (pls !== 4'b0110) $display("FAIL wait_ret_pulse: got %b want 0110", pls); else n_pass++;
  endtask

  task automatic test_both_keys;
    press(1'b1, 1'b1);
    n_total++; if ({flag_key_launch, flag_key_step} !== 2'b00) $display("FAIL both_flags: got %b want 00", {flag_key_launch, flag_key_step}); else n_pass++;
    n_total++; if (distance !== 20'd3) $display("FAIL both_hold: got %h want 3", distance); else n_pass++;
    press(1'b1, 1'b0);
    n_total++; if ({flag_key_launch, flag_key_step} !== 2'b10) $display("FAIL relaunch_flags: got %b want 10", {flag_key_launch, flag_key_step}); else n_pass++;
    n_total++; if (distance !== 20'd0) $display("FAIL relaunch_dist: got %h want 0", distance); else n_pass++;
  endtask

  task automatic test_saturate;
    logic [19:0] d1, d2, exp_d;
    logic [3:0]  pls, exp_pls;
    int          npulse;
    force dut.distance = 20'hFFFFE;
    tick(1);
    release dut.distance;
    tick(1);
    n_total++; if (distance !== 20'hFFFFE) $display("FAIL sat_preload: got %h want FFFFE", distance); else n_pass++;
    npulse = 0;
    for (int k = 1; k <= 6; k++) begin
      exp_d   = (k >= 3) ? 20'hFFFFF : 20'hFFFFE;
      exp_pls = (k == 3) ? 4'b0110 : 4'b0000;
      enc_edge(d1, d2, pls);
      npulse += (pls[1] ? 1 : 0);
      n_total++; if (d2 !== exp_d) $display("FAIL sat_dist_e%0d: got %h want %h", k, d2, exp_d); else n_pass++;
      n_total++; if (pls !== exp_pls) $display("FAIL sat_pulse_e%0d: got %b want %b", k, pls, exp_pls); else n_pass++;
    end
    n_total++; if (npulse !== 1) $display("FAIL sat_npulse: got %0d want 1", npulse); else n_pass++;
    n_total++; if (dut.presc !== 16'd0) $display("FAIL sat_presc: got %0d want 0", dut.presc); else n_pass++;
  endtask

  task automatic test_reset_mid_pulse;
    logic [19:0] d1, d2;
    logic [3:0]  pls;
    logic        found;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    enc_edge(d1, d2, pls);
    enc_edge(d1, d2, pls);
    key_step = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) encoder_raw = 1'b1;
      tick(1);
      if (flag_key_step && encoder_pulses) begin
        found = 1'b1;
        break;
      end
    end
    n_total++; if (found !== 1'b1) $display("FAIL mid_setup: got %b want pulse in WAIT", found); else n_pass++;
    n_total++; if (distance !== 20'd1) $display("FAIL mid_dist: got %h want 1", distance); else n_pass++;
    sys_rst_n = 1'b0;
    #1;
    n_total++; if ({flag_key_launch, flag_key_step} !== 2'b00) $display("FAIL mid_rst_flags: got %b want 00", {flag_key_launch, flag_key_step}); else n_pass++;
    n_total++; if (distance !== 20'd0) $display("FAIL mid_rst_dist: got %h want 0", distance); else n_pass++;
    n_total++; if (encoder_pulses !== 1'b0) $display("FAIL mid_rst_pulse: got %b want 0", encoder_pulses); else n_pass++;
    encoder_raw = 1'b0;
    key_step    = 1'b1;
    tick(2);
    sys_rst_n = 1'b1;
    tick(2);
    bounce_then_launch("post_rst");
  endtask

  initial begin
    test_reset();
    test_launch_debounce();
    test_count();
    test_wait();
    test_both_keys();
    test_saturate();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trip_ctrl.md
Name: trip_ctrl

Overview:
Front-end of the taxi meter.
- Debounces the launch and step push-buttons.
- Runs the trip state machine (idle / running / waiting) and drives flag_key_launch and flag_key_step.
- Synchronises the raw wheel encoder and accumulates distance.
- Emits a clean, registered encoder_pulses strobe per distance unit for the downstream fare counter, which clocks on encoder_pulses rising edges.

Parameters:
CNT_20MS, 20'd999_999, debounce stable-time in sys_clk cycles minus 1 (20 ms at 50 MHz)
PULSES_PER_UNIT, 16'd1000, encoder rising edges per distance unit
PULSE_W, 4'd4, high time of encoder_pulses in sys_clk cycles (>=2)

Ports:
sys_clk  input  1  system clock, single clock domain
sys_rst_n  input  1  asynchronous active-low reset
key_launch  input  1  raw launch button, active-low, asynchronous, bouncing
key_step  input  1  raw wait/resume button, active-low, asynchronous, bouncing
encoder_raw  input  1  raw wheel encoder, asynchronous
flag_key_launch  output  1  trip active (RUN or WAIT)
flag_key_step  output  1  trip waiting (WAIT only)
distance  output  20  distance units travelled in current trip
encoder_pulses  output  1  registered strobe, one per distance increment

Behaviour:
- Reset (async, sys_rst_n=0):
  - State IDLE; all outputs 0.
  - Prescaler, debounce counters and pulse timer cleared.
  - The synchronisers reset to 1 for keys and 0 for the encoder.
- Key filter, per key:
  - 2-flop synchroniser.
  - Counter clears whenever the synced level differs from its previous sample.
  - When the synced level has been low for CNT_20MS+1 consecutive cycles, emit exactly one 1-cycle press strobe.
  - No further strobe until the key is seen high, then low-stable again.
  - Release does not produce a strobe.
- Encoder:
  - 3-flop chain; rising edge = stage2 & ~stage3.
  - Latency from the input edge to the internal edge strobe is 3 cycles.
- FSM states and outputs (flag_key_launch, flag_key_step): IDLE (0,0), RUN (1,0), WAIT (1,1). Flags are registered, decoded from the state register.
- Transitions, evaluated on key strobes:
  - IDLE + launch -> RUN. Same cycle: distance <= 0, prescaler <= 0.
  - RUN + step -> WAIT.
  - WAIT + step -> RUN.
  - RUN or WAIT + launch -> IDLE. Distance is held for display.
  - Launch and step strobes in the same cycle: launch wins, step is discarded.
- Distance counting:
  - Encoder edges are counted by the prescaler only in RUN. Edges in IDLE or WAIT are dropped; the prescaler value is retained through WAIT.
  - When the prescaler reaches PULSES_PER_UNIT-1 and an edge arrives: prescaler <= 0 and distance <= distance+1.
  - distance saturates at 20'hFFFFF. At saturation the prescaler still wraps, but no pulse is emitted.
- encoder_pulses timing:
  - Rises exactly 1 sys_clk cycle after the distance increment, so distance is stable before the downstream edge.
  - Stays high PULSE_W cycles, then low.
  - An increment arriving while a pulse is still active sets a single-deep pending flag. The pending pulse starts after the line has been low for >=1 cycle.
  - A second overflow while pending is already set is lost. Document this; it is unreachable when PULSES_PER_UNIT > PULSE_W+2.
- Trip end during a pulse: an active pulse completes its full width; pending is cleared.
- Trip start in IDLE while a pulse is active: the pulse completes; distance clears as stated.
- encoder_pulses is driven only from a flop, never from combinational logic, because it is used as a clock downstream.

Decomposition:
- Shared package/header: FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_WAIT=2'd2; DIST_MAX=20'hFFFFF.
- Sub-module key_filter (params CNT_20MS; ports sys_clk, sys_rst_n, key_in, key_flag), instantiated twice.
- The encoder synchroniser, prescaler, FSM and pulse generator live in trip_ctrl.

Test Plan (CNT_20MS=3, PULSES_PER_UNIT=3, PULSE_W=2 unless noted):
1. Bounce key_launch 0/1 every 2 cycles for 10 cycles, then hold low 10 cycles -> exactly one strobe, 4 cycles after the final stable low; flag_key_launch=1, flag_key_step=0, distance=0.
2. In RUN, 7 encoder edges spaced 10 cycles apart -> distance 0->1 after edge 3 and 1->2 after edge 6. Each encoder_pulses is 2 cycles high, rising 1 cycle after distance changes; prescaler=1 at the end.
3. RUN, 2 edges, step press -> WAIT (flags 1,1). 5 edges in WAIT leave distance unchanged. Step press -> RUN; 1 edge -> distance increments (prescaler retained).
4. Launch and step pressed simultaneously in RUN -> IDLE (0,0), distance held. A new launch press -> RUN with distance=0.
5. Preload distance=20'hFFFFE, 6 edges -> distance=20'hFFFFF with only one encoder_pulses.
6. Assert sys_rst_n=0 mid-pulse in WAIT -> all outputs 0 immediately, state IDLE. After release, a bouncing key produces no strobe until stable.
